// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin over WIDTH bits, LSB first, one bit per clock,
// built from one full-subtractor cell and a borrow flip-flop behind a valid/ready handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sr_reg, b_sr_reg, res_sr_reg;
  logic [WIDTH-1:0] res_next;
  logic             a_msb_reg, b_msb_reg, br_reg;
  logic [CW-1:0]    cnt_reg;
  logic             d_bit, br_next, last_bit;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  assign d_bit    = a_sr_reg[0] ^ b_sr_reg[0] ^ br_reg;
  assign br_next  = (~a_sr_reg[0] & b_sr_reg[0]) | (~(a_sr_reg[0] ^ b_sr_reg[0]) & br_reg);
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  // New result bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    res_next = res_sr_reg >> 1;
    res_next[WIDTH-1] = d_bit;
  end

  assign in_ready = (state_reg == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      res_sr_reg <= '0;
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
      br_reg     <= 1'b0;
      cnt_reg    <= '0;
      diff       <= '0;
      bout       <= 1'b0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sr_reg  <= a;
            b_sr_reg  <= b;
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
            br_reg    <= bin;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          a_sr_reg   <= a_sr_reg >> 1;
          b_sr_reg   <= b_sr_reg >> 1;
          br_reg     <= br_next;
          res_sr_reg <= res_next;
          cnt_reg    <= cnt_reg + CW'(1);
          if (last_bit) begin
            // d_bit is the result MSB on the final step.
            diff      <= res_next;
            bout      <= br_next;
            overflow  <= (a_msb_reg ^ b_msb_reg) & (d_bit ^ a_msb_reg);
            out_valid <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
